// File: rtl/stats_frame_reader_pkg.sv
// rtl/stats_frame_reader_pkg.sv - shared frame layout, FSM states and byte helpers for the stats frame link
package stats_frame_reader_pkg;

  localparam int          FRAME_LEN      = 10;
  localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [3:0] IDX_HDR    = 4'd0;
  localparam logic [3:0] IDX_I_HI   = 4'd1;
  localparam logic [3:0] IDX_I_LO   = 4'd2;
  localparam logic [3:0] IDX_R_HI   = 4'd3;
  localparam logic [3:0] IDX_R_LO   = 4'd4;
  localparam logic [3:0] IDX_J_HI   = 4'd5;
  localparam logic [3:0] IDX_J_LO   = 4'd6;
  localparam logic [3:0] IDX_CLK_HI = 4'd7;
  localparam logic [3:0] IDX_CLK_LO = 4'd8;
  localparam logic [3:0] IDX_CSUM   = 4'(FRAME_LEN - 1);

  // Counters arrive zero-extended to 16 bits so hi/lo bytes are plain slices.
  function automatic logic [7:0] frame_csum(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c, input logic [15:0] d);
    return a[15:8] + a[7:0] + b[15:8] + b[7:0] + c[15:8] + c[7:0] + d[15:8] + d[7:0];
  endfunction

endpackage

// File: rtl/stats_frame_mux.sv
// rtl/stats_frame_mux.sv - combinational frame byte selector driven by the byte index
module stats_frame_mux
  import stats_frame_reader_pkg::*;
#(
  parameter int         CW     = 11,
  parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
  input  logic [CW-1:0] i_snap_i,
  input  logic [CW-1:0] i_snap_r,
  input  logic [CW-1:0] i_snap_j,
  input  logic [CW-1:0] i_snap_clk,
  input  logic [3:0]    i_idx,
  input  logic [7:0]    i_csum,
  output logic [7:0]    o_data
);

  logic [15:0] w_i;
  logic [15:0] w_r;
  logic [15:0] w_j;
  logic [15:0] w_clk;

  assign w_i   = 16'(i_snap_i);
  assign w_r   = 16'(i_snap_r);
  assign w_j   = 16'(i_snap_j);
  assign w_clk = 16'(i_snap_clk);

  always_comb begin
    o_data = 8'h00;
    case (i_idx)
      IDX_HDR:    o_data = HEADER;
      IDX_I_HI:   o_data = w_i[15:8];
      IDX_I_LO:   o_data = w_i[7:0];
      IDX_R_HI:   o_data = w_r[15:8];
      IDX_R_LO:   o_data = w_r[7:0];
      IDX_J_HI:   o_data = w_j[15:8];
      IDX_J_LO:   o_data = w_j[7:0];
      IDX_CLK_HI: o_data = w_clk[15:8];
      IDX_CLK_LO: o_data = w_clk[7:0];
      IDX_CSUM:   o_data = i_csum;
      default:    o_data = 8'h00;
    endcase
  end

endmodule

// File: rtl/stats_frame_reader.sv
// rtl/stats_frame_reader.sv - snapshots the instruction-class counters and streams them as a 10-byte frame
module stats_frame_reader
  import stats_frame_reader_pkg::*;
#(
  parameter int         CW     = 11,
  parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] i_cnt,
  input  logic [CW-1:0] r_cnt,
  input  logic [CW-1:0] j_cnt,
  input  logic [CW-1:0] clk_cnt,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_idx;
  logic [3:0]    w_next_idx;
  logic          w_capture;
  logic [CW-1:0] r_snap_i;
  logic [CW-1:0] r_snap_r;
  logic [CW-1:0] r_snap_j;
  logic [CW-1:0] r_snap_clk;
  logic [7:0]    w_csum;
  logic [7:0]    w_mux_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= 4'd0;
      r_snap_i   <= '0;
      r_snap_r   <= '0;
      r_snap_j   <= '0;
      r_snap_clk <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      if (w_capture) begin
        r_snap_i   <= i_cnt;
        r_snap_r   <= r_cnt;
        r_snap_j   <= j_cnt;
        r_snap_clk <= clk_cnt;
      end
    end
  end

  // Outputs decode from state only, so an asynchronous reset clears them at once.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_capture    = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = SEND;
          w_next_idx   = IDX_HDR;
          w_capture    = 1'b1;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          if (r_idx == IDX_CSUM) begin
            w_next_state = FINISH;
          end else begin
            w_next_idx = r_idx + 4'd1;
          end
        end
      end
      FINISH: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_csum = frame_csum(16'(r_snap_i), 16'(r_snap_r), 16'(r_snap_j), 16'(r_snap_clk));

  stats_frame_mux #(
    .CW     (CW),
    .HEADER (HEADER)
  ) u_mux (
    .i_snap_i   (r_snap_i),
    .i_snap_r   (r_snap_r),
    .i_snap_j   (r_snap_j),
    .i_snap_clk (r_snap_clk),
    .i_idx      (r_idx),
    .i_csum     (w_csum),
    .o_data     (w_mux_data)
  );

  assign out_data = (r_state == SEND) ? w_mux_data : 8'h00;

endmodule

// File: tb/tb_stats_frame_reader.sv
// tb/tb_stats_frame_reader.sv - directed self-checking bench for stats_frame_reader
module tb_stats_frame_reader;

  localparam int CW = 11;

  logic          clk;
  logic          reset;
  logic          start;
  logic [CW-1:0] i_cnt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] j_cnt;
  logic [CW-1:0] clk_cnt;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int tests_run;
  int tests_failed;

  logic [7:0] exp_basic [10];
  logic [7:0] exp_max   [10];

  stats_frame_reader #(.CW(CW), .HEADER(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .i_cnt     (i_cnt),
    .r_cnt     (r_cnt),
    .j_cnt     (j_cnt),
    .clk_cnt   (clk_cnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_busy", 32'(busy), 32'd1);
  endtask

  // Called at the negedge where byte 0 is first visible; pat[k%4] drives out_ready.
  task automatic recv_frame(input string name, input logic [7:0] exp[10], input logic [3:0] pat,
                            input bit inject, input int stop_after);
    int  n;
    bit  stalled;
    logic [7:0] held;
    n = 0;
    stalled = 1'b0;
    held = 8'h00;
    for (int k = 0; k < 60; k++) begin
      out_ready = pat[k % 4];
      if (inject && k == 3) begin
        i_cnt = 11'd100;
        start = 1'b1;
      end
      if (inject && k == 4) start = 1'b0;
      if (inject) check({name, "_busy"}, 32'(busy), 32'd1);
      if (stalled) begin
        check({name, "_stall_valid"}, 32'(out_valid), 32'd1);
        check({name, "_stall_data"}, 32'(out_data), 32'(held));
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        check($sformatf("%s_byte%0d", name, n), 32'(out_data), 32'(exp[n]));
        n++;
        if (n == stop_after) return;
      end
      @(negedge clk);
    end
    check({name, "_timeout"}, 32'(n), 32'(stop_after));
  endtask

  task automatic check_finish(input string name);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_fin_busy"}, 32'(busy), 32'd1);
    check({name, "_fin_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, "_done_clr"}, 32'(done), 32'd0);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    exp_basic = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h09, 8'h12};
    exp_max   = '{8'hA5, 8'h07, 8'hFF, 8'h07, 8'hFF, 8'h07, 8'hFF, 8'h07, 8'hFF, 8'h18};
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    i_cnt = 11'd5;
    r_cnt = 11'd3;
    j_cnt = 11'd1;
    clk_cnt = 11'd9;
    repeat (2) @(negedge clk);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    // out_ready high while idle has no effect
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_ready_valid", 32'(out_valid), 32'd0);

    pulse_start();
    recv_frame("basic", exp_basic, 4'b1111, 1'b0, 10);
    @(negedge clk);
    check_finish("basic");

    i_cnt = 11'h7FF; r_cnt = 11'h7FF; j_cnt = 11'h7FF; clk_cnt = 11'h7FF;
    pulse_start();
    recv_frame("max", exp_max, 4'b1111, 1'b0, 10);
    @(negedge clk);
    check_finish("max");

    i_cnt = 11'd5; r_cnt = 11'd3; j_cnt = 11'd1; clk_cnt = 11'd9;
    pulse_start();
    recv_frame("bp", exp_basic, 4'b1001, 1'b0, 10);
    @(negedge clk);
    check_finish("bp");

    pulse_start();
    recv_frame("snap", exp_basic, 4'b1111, 1'b1, 10);
    @(negedge clk);
    check_finish("snap");
    repeat (3) begin
      @(negedge clk);
      check("snap_no_second_frame", 32'(out_valid), 32'd0);
    end
    i_cnt = 11'd5;

    pulse_start();
    recv_frame("abort", exp_basic, 4'b1111, 1'b0, 5);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_data", 32'(out_data), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle_valid", 32'(out_valid), 32'd0);
    pulse_start();
    recv_frame("after_abort", exp_basic, 4'b1111, 1'b0, 10);
    @(negedge clk);
    check_finish("after_abort");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
